// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive 4-input response capture and compare engine (optional TT_FIRST_FAIL_EN adds first_fail)
module truth_table_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    input  logic [15:0] expected,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic [15:0] tt,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  mismatch_cnt
`ifdef TT_FIRST_FAIL_EN
    ,
    output logic [4:0]  first_fail
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  settle_q, settle_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  ff_q, ff_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        ff_d     = ff_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    tt_d    = 16'h0000;
                    cnt_d   = 5'd0;
                    idx_d   = 4'd0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    ff_d    = 5'h10;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = 8'd0;
                state_d  = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                tt_d[idx_q] = f_in;
                if (f_in != exp_q[idx_q]) begin
                    cnt_d = cnt_q + 5'd1;
                    // first_fail keeps only the earliest mismatch; 5'h10 marks "none yet"
                    if (ff_q[4]) begin
                        ff_d = {1'b0, idx_q};
                    end
                end
                if (idx_q == 4'd15) begin
                    idx_d   = 4'd0;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = (cnt_q == 5'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            exp_q    <= 16'h0000;
            tt_q     <= 16'h0000;
            cnt_q    <= 5'd0;
            settle_q <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            ff_q     <= 5'h10;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            ff_q     <= ff_d;
        end
    end

    assign {A, B, C, D}  = idx_q;
    assign tt            = tt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign mismatch_cnt  = cnt_q;
`ifdef TT_FIRST_FAIL_EN
    assign first_fail    = ff_q;
`else
    logic unused_ff;
    assign unused_ff = ^ff_q;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - table-driven bench for truth_table_checker (default and zero-settle instances)
module tb_truth_table_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] expected = 16'h0000;
    logic        f_a, f_b;
    logic        A_a, B_a, C_a, D_a, A_b, B_b, C_b, D_b;
    logic [15:0] tt_a, tt_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [4:0]  cnt_a, cnt_b;
`ifdef TT_FIRST_FAIL_EN
    logic [4:0]  ff_a, ff_b;
`endif

    int mode_a = 0;
    int mode_b = 0;
    int unit = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Bench model of the lab block: 0 A&B, 1 const 0, 2 D, 3 A|C, 4 ~A
    function automatic logic fmodel(input int m, input logic [3:0] v);
        case (m)
            0: fmodel = v[3] & v[2];
            1: fmodel = 1'b0;
            2: fmodel = v[0];
            3: fmodel = v[3] | v[1];
            4: fmodel = ~v[3];
            default: fmodel = 1'b0;
        endcase
    endfunction

    assign f_a = fmodel(mode_a, {A_a, B_a, C_a, D_a});
    assign f_b = fmodel(mode_b, {A_b, B_b, C_b, D_b});

    truth_table_checker dut (
        .clk(clk), .rst(rst), .start(start_a), .f_in(f_a), .expected(expected),
        .A(A_a), .B(B_a), .C(C_a), .D(D_a), .tt(tt_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .mismatch_cnt(cnt_a)
`ifdef TT_FIRST_FAIL_EN
        , .first_fail(ff_a)
`endif
    );

    truth_table_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_b), .f_in(f_b), .expected(expected),
        .A(A_b), .B(B_b), .C(C_b), .D(D_b), .tt(tt_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .mismatch_cnt(cnt_b)
`ifdef TT_FIRST_FAIL_EN
        , .first_fail(ff_b)
`endif
    );

    logic [3:0]  m_abcd;
    logic [15:0] m_tt;
    logic        m_busy, m_done, m_pass;
    logic [4:0]  m_cnt;
    assign m_abcd = (unit == 0) ? {A_a, B_a, C_a, D_a} : {A_b, B_b, C_b, D_b};
    assign m_tt   = (unit == 0) ? tt_a : tt_b;
    assign m_busy = (unit == 0) ? busy_a : busy_b;
    assign m_done = (unit == 0) ? done_a : done_b;
    assign m_pass = (unit == 0) ? pass_a : pass_b;
    assign m_cnt  = (unit == 0) ? cnt_a : cnt_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic set_start(input logic v);
        if (unit == 0) start_a = v;
        else start_b = v;
    endtask

    typedef struct {
        int          u;
        int          mode;
        logic [15:0] exp_tbl;
        logic [15:0] e_tt;
        logic [4:0]  e_cnt;
        logic        e_pass;
        logic [4:0]  e_ff;
        int          e_lat;
        int          e_hold;
        string       name;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int cyc;
        int hold[16];
        bit hold_ok;
        unit = v.u;
        if (v.u == 0) mode_a = v.mode;
        else mode_b = v.mode;
        for (int i = 0; i < 16; i++) hold[i] = 0;
        @(posedge clk); #1;
        expected = v.exp_tbl;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        chk({v.name, " busy_after_start"}, 32'(m_busy), 32'd1);
        cyc = 0;
        while (!m_done && cyc < 200) begin
            if (m_busy) hold[m_abcd]++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({v.name, " done_latency"}, 32'(cyc), 32'(v.e_lat));
        chk({v.name, " tt"}, 32'(m_tt), 32'(v.e_tt));
        chk({v.name, " mismatch_cnt"}, 32'(m_cnt), 32'(v.e_cnt));
        chk({v.name, " pass"}, 32'(m_pass), 32'(v.e_pass));
        chk({v.name, " abcd_after_done"}, 32'(m_abcd), 32'd0);
        chk({v.name, " busy_at_done"}, 32'(m_busy), 32'd0);
`ifdef TT_FIRST_FAIL_EN
        chk({v.name, " first_fail"}, 32'((v.u == 0) ? ff_a : ff_b), 32'(v.e_ff));
`endif
        hold_ok = 1'b1;
        for (int i = 0; i < 16; i++) if (hold[i] != v.e_hold) hold_ok = 1'b0;
        chk({v.name, " vector_hold"}, 32'(hold_ok), 32'd1);
        @(posedge clk); #1;
        chk({v.name, " done_one_pulse"}, 32'(m_done), 32'd0);
        chk({v.name, " pass_holds"}, 32'(m_pass), 32'(v.e_pass));
    endtask

    vec_t tbl[5];

    initial begin
        int cyc;
        int ndone;
        int done_cyc;
        bit injected;

        tbl[0] = '{0, 0, 16'hF000, 16'hF000, 5'd0,  1'b1, 5'h10, 65, 4, "and_ab"};
        tbl[1] = '{0, 1, 16'hFFFF, 16'h0000, 5'd16, 1'b0, 5'h00, 65, 4, "zero"};
        tbl[2] = '{0, 2, 16'hAAAB, 16'hAAAA, 5'd1,  1'b0, 5'h00, 65, 4, "f_eq_d"};
        tbl[3] = '{0, 3, 16'hFFCC, 16'hFFCC, 5'd0,  1'b1, 5'h10, 65, 4, "a_or_c"};
        tbl[4] = '{1, 4, 16'h00FF, 16'h00FF, 5'd0,  1'b1, 5'h10, 33, 2, "settle0_not_a"};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy_a), 32'd0);
        chk("reset done", 32'(done_a), 32'd0);
        chk("reset pass", 32'(pass_a), 32'd0);
        chk("reset tt", 32'(tt_a), 32'd0);
        chk("reset cnt", 32'(cnt_a), 32'd0);
        chk("reset abcd", 32'({A_a, B_a, C_a, D_a}), 32'd0);
`ifdef TT_FIRST_FAIL_EN
        chk("reset first_fail", 32'(ff_a), 32'h10);
`endif
        rst = 1'b0;

        for (int i = 0; i < 3; i++) run_vec(tbl[i]);

        // Reset mid-run at idx 7: everything clears, no done pulse follows
        unit = 0;
        mode_a = 0;
        expected = 16'hF000;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (!({A_a, B_a, C_a, D_a} == 4'd7 && busy_a) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst reached idx7", 32'(cyc < 100), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst tt", 32'(tt_a), 32'd0);
        chk("rst cnt", 32'(cnt_a), 32'd0);
        chk("rst abcd", 32'({A_a, B_a, C_a, D_a}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done_a) ndone++;
        end
        chk("rst no done", 32'(ndone), 32'd0);
        run_vec(tbl[3]);

        // Second start and expected change during the run must be ignored
        mode_a = 0;
        expected = 16'hF000;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        ndone = 0;
        done_cyc = -1;
        injected = 1'b0;
        while (cyc < 120) begin
            @(posedge clk); #1;
            cyc++;
            start_a = 1'b0;
            if (done_a) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (!injected && busy_a && {A_a, B_a, C_a, D_a} == 4'd5) begin
                injected = 1'b1;
                start_a = 1'b1;
                expected = 16'h0000;
            end
        end
        chk("restart done_latency", 32'(done_cyc), 32'd65);
        chk("restart done_count", 32'(ndone), 32'd1);
        chk("restart tt", 32'(tt_a), 32'hF000);
        chk("restart pass", 32'(pass_a), 32'd1);
        chk("restart cnt", 32'(cnt_a), 32'd0);

        run_vec(tbl[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
